// File: rtl/adder_tree_accumulator.sv
// adder_tree_accumulator: sums blocks of N_SAMPLES adder-tree results
// and presents the block total and floor average over valid/ready.
module adder_tree_accumulator #(
  parameter int IN_W      = 10,
  parameter int N_SAMPLES = 4,
  localparam int LG       = $clog2(N_SAMPLES),
  localparam int ACC_W    = IN_W + LG,
  localparam int CW       = LG + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [IN_W-1:0]  out_avg,
  output logic [CW-1:0]    sample_cnt
);

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] total;

  assign in_ready = (state == ACCUM);
  assign accept   = in_valid && in_ready;
  assign last     = (sample_cnt == CW'(N_SAMPLES - 1));
  assign total    = acc + ACC_W'(in_data);

  always_ff @(posedge clk) begin
    if (reset) state <= ACCUM;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACCUM: if (accept && last) state_nxt = HOLD;
      HOLD:  if (out_ready)      state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // acc only moves on an accepted sample, so idle in_data is never summed
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      sample_cnt <= '0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_avg    <= '0;
    end else begin
      if (accept) begin
        if (last) begin
          out_sum    <= total;
          out_avg    <= total[ACC_W-1:LG];
          out_valid  <= 1'b1;
          acc        <= '0;
          sample_cnt <= '0;
        end else begin
          acc        <= total;
          sample_cnt <= sample_cnt + CW'(1);
        end
      end
      if (out_valid && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_tree_accumulator.sv
// Bench for adder_tree_accumulator: block-level model plus directed
// vectors with literal expected totals and averages.
module tb_adder_tree_accumulator;

  localparam int IN_W  = 10;
  localparam int N     = 4;
  localparam int ACC_W = 12;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_sum;
  logic [IN_W-1:0]  out_avg;
  logic [CW-1:0]    sample_cnt;

  adder_tree_accumulator #(
    .IN_W(IN_W),
    .N_SAMPLES(N)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_avg(out_avg),
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // block model: a list of pending samples and the last completed block
  int q[$];
  int done[$];
  bit exp_valid = 0;
  int exp_sum = 0;
  int exp_avg = 0;
  bit started = 0;

  always @(posedge clk) begin
    bit rdy;
    int s;
    if (reset) begin
      q.delete();
      exp_valid = 0;
      exp_sum   = 0;
      exp_avg   = 0;
      started   = 1;
    end else if (started) begin
      rdy = !exp_valid;
      if (exp_valid && out_ready) exp_valid = 0;
      if (in_valid && rdy) begin
        q.push_back(int'(in_data));
        if (q.size() == N) begin
          s = 0;
          foreach (q[i]) s += q[i];
          exp_sum   = s;
          exp_avg   = s / N;
          exp_valid = 1;
          done.push_back(s);
          q.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("out_valid", int'(out_valid), int'(exp_valid));
      check("in_ready", int'(in_ready), int'(!exp_valid));
      check("sample_cnt", int'(sample_cnt), q.size());
      check("out_sum", int'(out_sum), exp_sum);
      check("out_avg", int'(out_avg), exp_avg);
    end
  end

  // caller sits just after a negedge; returns just after the accepting edge
  task automatic send(int v);
    int n;
    in_valid = 1'b1;
    in_data  = IN_W'(v);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("send_timeout", 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(string name, int s, int a);
    check({name, "_valid"}, int'(out_valid), 1);
    check({name, "_sum"}, int'(out_sum), s);
    check({name, "_avg"}, int'(out_avg), a);
  endtask

  int exp_done[8] = '{597, 4092, 100, 26, 83, 10, 36, 22};

  initial begin
    idle(2);
    reset = 1'b0;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_avg", int'(out_avg), 0);
    check("rst_cnt", int'(sample_cnt), 0);

    send(259); send(33); send(206); send(99);
    lit("b2b", 597, 149);
    idle(1);
    check("b2b_ready_back", int'(in_ready), 1);

    repeat (4) send(1023);
    lit("max", 4092, 1023);
    idle(1);

    send(10);
    check("bub_cnt1", int'(sample_cnt), 1);
    idle(2);
    send(20);
    check("bub_cnt2", int'(sample_cnt), 2);
    idle(2);
    send(30);
    check("bub_cnt3", int'(sample_cnt), 3);
    idle(2);
    send(40);
    check("bub_cnt0", int'(sample_cnt), 0);
    lit("bub", 100, 25);
    idle(1);

    out_ready = 1'b0;
    send(5); send(6); send(7); send(8);
    in_valid = 1'b1;
    in_data  = 10'd77;
    repeat (5) begin
      lit("bp", 26, 6);
      check("bp_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_back", int'(in_ready), 1);
    check("bp_cnt0", int'(sample_cnt), 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 'x;
    check("bp_carry_cnt", int'(sample_cnt), 1);
    send(1); send(2); send(3);
    lit("bp_next", 83, 20);
    idle(1);

    send(100); send(200);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rmid_cnt", int'(sample_cnt), 0);
    send(1); send(2); send(3); send(4);
    lit("rmid", 10, 2);
    idle(1);

    out_ready = 1'b0;
    repeat (4) send(9);
    lit("rhold_pre", 36, 9);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rhold_valid", int'(out_valid), 0);
    check("rhold_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    send(4); send(5); send(6); send(7);
    lit("rhold_next", 22, 5);
    idle(2);

    check("block_count", done.size(), 8);
    foreach (exp_done[i]) begin
      if (i < done.size()) check("model_block", done[i], exp_done[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_tree_accumulator.md
Name: adder_tree_accumulator

Overview:
- Downstream stage of the adder tree. Consumes the tree's 10-bit final sum (sum3) one sample at a time over a valid/ready handshake.
- Accumulates a block of N_SAMPLES values, then presents the block total and the block average, also over a valid/ready handshake.
- Registered, single clock domain. Its output feeds later averaging and display logic.

Parameters:
- IN_W, 10, width of the input sample. Matches the adder tree's sum3 width.
- N_SAMPLES, 4, samples per block. Must be a power of 2 and at least 2.
- ACC_W (localparam), IN_W + $clog2(N_SAMPLES), accumulator and output total width. This width cannot overflow.

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a valid sample.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  IN_W  sample value, unsigned (the adder tree's sum3).
- out_valid  output  1  out_sum and out_avg hold a completed block.
- out_ready  input  1  downstream accepts the block this cycle.
- out_sum  output  ACC_W  unsigned sum of the N_SAMPLES accepted samples.
- out_avg  output  IN_W  out_sum >> $clog2(N_SAMPLES), truncated (floor).
- sample_cnt  output  $clog2(N_SAMPLES)+1  samples accepted in the current block.

Behaviour:
- Reset is synchronous and active-high. Reset is sampled only at the clk rising edge.
- Reset values: state=ACCUM, acc=0, sample_cnt=0, out_valid=0, out_sum=0, out_avg=0, in_ready=1 in the first cycle after reset.
- Two-state FSM: ACCUM and HOLD.
- ACCUM state:
  - in_ready=1 and out_valid=0.
  - Accept occurs when in_valid && in_ready at the edge. On accept: acc <= acc + in_data (zero-extended to ACC_W) and sample_cnt <= sample_cnt + 1.
  - No accept means no state change. Bubbles (in_valid=0) are allowed anywhere in a block.
- ACCUM to HOLD: when an accept happens with sample_cnt == N_SAMPLES-1:
  - out_sum <= acc + in_data and out_avg <= (acc + in_data) >> log2(N_SAMPLES), both registered.
  - out_valid <= 1, acc <= 0, sample_cnt <= 0, state <= HOLD.
  - Latency: out_valid is high in the cycle after the last sample is accepted.
- HOLD state:
  - in_ready=0, so input samples are not accepted. The upstream producer must hold its data.
  - out_sum and out_avg stay stable while out_valid=1 && out_ready=0.
  - When out_valid && out_ready at the edge: out_valid <= 0, state <= ACCUM. in_ready returns to 1 in the next cycle.
  - out_sum and out_avg keep their last value after the handshake, but are meaningful only while out_valid=1.
- in_ready is a combinational decode of state only. It does not depend on out_ready, and there is no same-cycle pass-through.
- Maximum sustained throughput: N_SAMPLES accepts, then at least 1 HOLD cycle. That gives a minimum block period of N_SAMPLES+1 cycles.
- Widths: unsigned arithmetic only. The maximum total, N_SAMPLES*(2^IN_W - 1), fits in ACC_W. No saturation is needed.
- Reset mid-block: the partial accumulation is discarded and there is no output.
- Reset during HOLD: the pending result is dropped and out_valid goes to 0 in the next cycle.
- Reset has priority over any simultaneous handshake.
- in_valid during HOLD: ignored. No sample is lost from the upstream view because in_ready=0.
- X on in_data while in_valid=0 must not corrupt acc.

Test Plan:
- Back-to-back samples 259, 33, 206, 99 with out_ready=1 -> one cycle after the 4th accept: out_valid=1, out_sum=597, out_avg=149. Then in_ready=1 again in the following cycle.
- Maximum values: four samples of 1023 -> out_sum=4092 (12'hFFC), out_avg=1023. No wrap.
- Bubbles: samples 10, 20, 30, 40 with 2 idle cycles between each -> out_sum=100, out_avg=25. sample_cnt steps 1, 2, 3, then 0 when HOLD is entered.
- Backpressure: out_ready held at 0 for 5 cycles after the block completes -> out_valid, out_sum and out_avg are stable, and in_ready=0 throughout. A 5th sample presented during HOLD is accepted only after the handshake and lands in the next block.
- Reset mid-block: accept 100 and 200, assert reset for 1 cycle, then accept 1, 2, 3, 4 -> out_sum=10, out_avg=2. The pre-reset samples are not included.
- Reset during HOLD with out_ready=0 -> out_valid=0 and in_ready=1 in the cycle after reset. The next block's result is correct.
